fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared constants for the instruction fetch stage: fetch FSM state
//   encodings, the NOP opcode forced onto the decoder while nothing valid is
//   held, and the word-select bit that forms the low bit of the memory
//   word address.
package fetch_unit_pkg;

  // Fetch FSM state encodings
  localparam logic [1:0] F_OPC = 2'd0;
  localparam logic [1:0] F_IMM = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  // Opcode presented to the decoder when no valid instruction is held
  localparam logic [15:0] NOP_OPC = 16'h0000;

  // Low bit of imem_addr: which half of the instruction pair is requested
  localparam logic OPC_WORD = 1'b0;
  localparam logic IMM_WORD = 1'b1;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage in front of the core decoder. Owns the program
//   counter, fetches each instruction as an opcode word followed by an
//   immediate word, presents the pair to the decoder and retires it on
//   pc_inc / pc_ie. A NOP is forced onto instr while no complete pair is held.
//
// Ports
//   clk, rst        core clock, synchronous active-high reset
//   imem_req/addr   instruction memory request, word address {pc, word_sel}
//   imem_ack/rdata  request completion and read data (same cycle)
//   instr, imm      opcode word (NOP when invalid) and immediate word
//   instr_valid     instr/imm hold a complete fetched instruction
//   pc, pc_next     PC of the presented instruction and pc+1 (wrapping)
//   pc_inc, pc_ie   decoder retire: sequential advance / load pc_in
//   pc_in           jump target
//
// State table
//   state | meaning
//   F_OPC | requesting opcode word {pc,0}
//   F_IMM | requesting immediate word {pc,1}
//   READY | pair held and presented, waiting for decoder to retire it
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W:0]   imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     instr,
  output logic [15:0]     imm,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next,
  input  logic            pc_inc,
  input  logic            pc_ie,
  input  logic [PC_W-1:0] pc_in
);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     opc_q, opc_d;
  logic [15:0]     imm_q, imm_d;
  logic            word_sel;
  logic [PC_W-1:0] pc_plus1;

  assign pc_plus1 = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opc_d    = opc_q;
    imm_d    = imm_q;
    imem_req = 1'b0;
    word_sel = OPC_WORD;

    case (state_q)
      F_OPC: begin
        imem_req = 1'b1;
        word_sel = OPC_WORD;
        if (imem_ack) begin
          opc_d   = imem_rdata;
          state_d = F_IMM;
        end
      end

      F_IMM: begin
        imem_req = 1'b1;
        word_sel = IMM_WORD;
        if (imem_ack) begin
          imm_d   = imem_rdata;
          state_d = READY;
        end
      end

      READY: begin
        // A jump wins over a sequential advance when the decoder raises both.
        if (pc_ie) begin
          pc_d    = pc_in;
          state_d = F_OPC;
        end else if (pc_inc) begin
          pc_d    = pc_plus1;
          state_d = F_OPC;
        end
      end

      default: begin
        state_d = F_OPC;
      end
    endcase
  end

  // Reset wins over everything, including an ack landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= F_OPC;
      pc_q    <= RESET_PC;
      opc_q   <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      imm_q   <= imm_d;
    end
  end

  assign imem_addr   = {pc_q, word_sel};
  assign instr_valid = (state_q == READY);
  assign instr       = instr_valid ? opc_q : NOP_OPC;
  assign imm         = imm_q;
  assign pc          = pc_q;
  assign pc_next     = pc_plus1;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Randomized bench for fetch_unit with a transaction-level reference model:
//   every retire (or reset) queues the two word addresses the fetch stage must
//   request next; each ack consumes one queued address and captures its data.
//   The instruction is expected valid exactly when the queue is empty.
module tb_fetch_unit;

  localparam int          PC_W   = 16;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req;
  logic [PC_W:0]   imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;
  logic [15:0]     instr;
  logic [15:0]     imm;
  logic            instr_valid;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic            pc_inc;
  logic            pc_ie;
  logic [PC_W-1:0] pc_in;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .imm         (imm),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_next     (pc_next),
    .pc_inc      (pc_inc),
    .pc_ie       (pc_ie),
    .pc_in       (pc_in)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model
  logic [16:0] exp_q[$];
  logic [15:0] cap[$];
  logic [15:0] m_pc;
  logic [15:0] m_imm;
  int          since;
  bit          all_zero;
  bit          prev_valid;

  // memory responder / decoder knobs
  bit          in_wait;
  int          wcnt;
  int          wtgt;
  bit          rand_wait;
  int          fix_wait;
  bit          dir;
  logic        d_inc;
  logic        d_ie;
  logic [15:0] d_pcin;

  function automatic logic [15:0] mem_word(input logic [16:0] a);
    logic [31:0] h;
    if (a == 17'd0) return 16'h0007;
    if (a == 17'd1) return 16'h1234;
    h = {15'd0, a} * 32'h9E37_79B1;
    return h[31:16] ^ h[15:0];
  endfunction

  task automatic queue_fetch(input logic [15:0] p);
    exp_q.push_back({p, 1'b0});
    exp_q.push_back({p, 1'b1});
  endtask

  task automatic model_reset();
    exp_q.delete();
    cap.delete();
    m_pc       = RST_PC;
    m_imm      = 16'h0000;
    queue_fetch(RST_PC);
    since      = 0;
    all_zero   = 1'b1;
    prev_valid = 1'b0;
    in_wait    = 1'b0;
  endtask

  // One clock: check outputs (we sit #1 after a posedge), drive inputs,
  // advance the model for the coming edge, then move to the next sample point.
  task automatic step(input bit rst_req);
    bit          ev;
    logic [15:0] npc;
    int          r;
    since++;
    ev  = (exp_q.size() == 0);
    npc = m_pc + 16'd1;
    chk("valid",   32'(instr_valid), 32'(ev));
    chk("req",     32'(imem_req),    32'(!ev));
    chk("pc",      32'(pc),          32'(m_pc));
    chk("pc_next", 32'(pc_next),     32'(npc));
    chk("imm",     32'(imm),         32'(m_imm));
    if (!ev) begin
      chk("addr",     32'(imem_addr), 32'(exp_q[0]));
      chk("nop",      32'(instr),     32'h0);
      chk("progress", 32'(since <= 24), 32'd1);
    end else begin
      chk("instr",   32'(instr), 32'(cap[0]));
      chk("imm_cap", 32'(imm),   32'(cap[1]));
      if (!prev_valid && all_zero) chk("latency", 32'(since), 32'd3);
    end
    prev_valid = ev;

    rst = rst_req;

    if (rst_req) begin
      imem_ack   = 1'b1;
      imem_rdata = 16'hBEEF;
    end else if (imem_req) begin
      if (!in_wait) begin
        in_wait = 1'b1;
        wcnt    = 0;
        wtgt    = rand_wait ? int'($urandom_range(0, 3)) : fix_wait;
      end
      if (wcnt == wtgt) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        in_wait    = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        wcnt++;
      end
    end else begin
      imem_ack   = ($urandom_range(0, 3) == 0);
      imem_rdata = 16'($urandom);
    end

    if (dir) begin
      pc_inc = d_inc;
      pc_ie  = d_ie;
      pc_in  = d_pcin;
    end else if (ev) begin
      r      = int'($urandom_range(0, 9));
      pc_inc = (r >= 4);
      pc_ie  = (r >= 8);
      pc_in  = (r == 9) ? 16'hFFFF : 16'($urandom);
    end else begin
      pc_inc = 1'($urandom_range(0, 1));
      pc_ie  = ($urandom_range(0, 3) == 0);
      pc_in  = 16'($urandom);
    end

    if (rst_req) begin
      model_reset();
    end else begin
      if (!ev) begin
        if (imem_ack) begin
          cap.push_back(imem_rdata);
          void'(exp_q.pop_front());
          if (cap.size() == 2) m_imm = imem_rdata;
        end else begin
          all_zero = 1'b0;
        end
      end
      if (ev && (pc_ie || pc_inc)) begin
        m_pc = pc_ie ? pc_in : npc;
        cap.delete();
        queue_fetch(m_pc);
        since    = 0;
        all_zero = 1'b1;
      end
    end

    @(posedge clk);
    #1;
  endtask

  task automatic run_until_valid(input int max);
    int n = 0;
    while (!instr_valid && n < max) begin
      step(1'b0);
      n++;
    end
    chk("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0;
    pc_inc     = 1'b0;
    pc_ie      = 1'b0;
    pc_in      = 16'h0;
    dir        = 1'b1;
    d_inc      = 1'b0;
    d_ie       = 1'b0;
    d_pcin     = 16'h0;
    rand_wait  = 1'b0;
    fix_wait   = 0;
    wcnt       = 0;
    wtgt       = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // zero-wait first fetch after reset
    chk("t1_addr0", 32'(imem_addr), 32'h0);
    step(1'b0);
    chk("t1_addr1", 32'(imem_addr), 32'h1);
    step(1'b0);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_instr", 32'(instr), 32'h0007);
    chk("t1_imm",   32'(imm),   32'h1234);

    // decoder stall, then sequential retire
    repeat (5) step(1'b0);
    d_inc = 1'b1;
    step(1'b0);
    d_inc = 1'b0;
    chk("t2_pc",   32'(pc),        32'h0001);
    chk("t2_addr", 32'(imem_addr), 32'h2);
    run_until_valid(30);

    // jump with pc_ie and pc_inc together
    d_ie   = 1'b1;
    d_inc  = 1'b1;
    d_pcin = 16'h00A0;
    step(1'b0);
    d_ie  = 1'b0;
    d_inc = 1'b0;
    chk("t3_addr", 32'(imem_addr), 32'h00140);
    run_until_valid(30);
    chk("t3_pc_next", 32'(pc_next), 32'h00A1);

    // three wait cycles per word, pc_inc held high during the fetch
    fix_wait = 3;
    d_inc    = 1'b1;
    step(1'b0);
    repeat (8) step(1'b0);
    d_inc = 1'b0;
    chk("t4_valid", 32'(instr_valid), 32'd1);
    chk("t4_pc",    32'(pc),          32'h00A1);
    fix_wait = 0;

    // pc wrap
    d_ie   = 1'b1;
    d_pcin = 16'hFFFF;
    step(1'b0);
    d_ie = 1'b0;
    run_until_valid(30);
    chk("t5_pc_ffff", 32'(pc), 32'hFFFF);
    d_inc = 1'b1;
    step(1'b0);
    d_inc = 1'b0;
    chk("t5_pc",   32'(pc),        32'h0000);
    chk("t5_addr", 32'(imem_addr), 32'h0);

    // reset in F_IMM with a coincident ack
    run_until_valid(30);
    d_ie   = 1'b1;
    d_pcin = 16'h0333;
    step(1'b0);
    d_ie = 1'b0;
    step(1'b0);
    chk("t6_in_imm", 32'(imem_addr[0]), 32'd1);
    step(1'b1);
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_addr",  32'(imem_addr),   32'(RST_PC) << 1);
    chk("t6_pc",    32'(pc),          32'(RST_PC));
    chk("t6_instr", 32'(instr),       32'h0);

    // random traffic with random waits, stray acks and occasional resets
    dir       = 1'b0;
    rand_wait = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_unit
